// File: rtl/char_buffer_ctrl_if.sv
// Command port bundle between the keyboard decoder (master) and the character buffer (slave).
interface char_buffer_ctrl_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 9
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_data;

    modport master (output cmd_valid, output cmd_op, output cmd_addr, output cmd_data,
                    input  cmd_ready);
    modport slave  (input  cmd_valid, input  cmd_op, input  cmd_addr, input  cmd_data,
                    output cmd_ready);
endinterface

// File: rtl/char_buffer_ctrl.sv
// Character-cell text buffer: command-driven cell writes with a cursor, a sequential clear
// sweep, and a registered read port with a dirty flag for the LCD refresher.
module char_buffer_ctrl #(
    parameter int unsigned       DEPTH  = 32,
    parameter int unsigned       ADDR_W = 5,
    parameter int unsigned       DATA_W = 9,
    parameter logic [DATA_W-1:0] FILL   = DATA_W'('h120)
) (
    input  logic                 clk,
    input  logic                 rst,
    char_buffer_ctrl_if.slave    cmd,
    input  logic [ADDR_W-1:0]    rd_addr_i,
    output logic [DATA_W-1:0]    rd_data_o,
    output logic [ADDR_W-1:0]    cursor_o,
    output logic                 busy_o,
    output logic                 dirty_o,
    input  logic                 dirty_clr_i
);
    localparam int unsigned     IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

    localparam logic [1:0] OP_WRITE  = 2'b00;
    localparam logic [1:0] OP_APPEND = 2'b01;
    localparam logic [1:0] OP_BKSP   = 2'b10;
    localparam logic [1:0] OP_CLEAR  = 2'b11;

    typedef enum logic {ST_IDLE, ST_CLR} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
    logic [ADDR_W-1:0]   cursor_q, cursor_d;
    logic                dirty_q, dirty_d;
    logic                cmd_ready_q, busy_q;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                we;
    logic [ADDR_W-1:0]   waddr;
    logic [DATA_W-1:0]   wdata;
    logic                dirty_set;
    logic                accept;

    assign accept = cmd.cmd_valid && cmd_ready_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_CLR;
        else     state_q <= state_d;
    end

    // Next state, single write port arbitration and cursor update
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        cursor_d  = cursor_q;
        dirty_set = 1'b0;
        we        = 1'b0;
        waddr     = clr_ptr_q;
        wdata     = FILL;
        case (state_q)
            ST_CLR: begin
                we = 1'b1;
                if (clr_ptr_q == LAST) begin
                    state_d   = ST_IDLE;
                    clr_ptr_d = '0;
                    dirty_set = 1'b1;
                end else begin
                    clr_ptr_d = clr_ptr_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (accept) begin
                    case (cmd.cmd_op)
                        OP_WRITE: begin
                            if ({1'b0, cmd.cmd_addr} < DEPTH_X) begin
                                we        = 1'b1;
                                waddr     = cmd.cmd_addr;
                                wdata     = cmd.cmd_data;
                                dirty_set = 1'b1;
                            end
                        end
                        OP_APPEND: begin
                            we        = 1'b1;
                            waddr     = cursor_q;
                            wdata     = cmd.cmd_data;
                            dirty_set = 1'b1;
                            cursor_d  = (cursor_q == LAST) ? '0 : cursor_q + 1'b1;
                        end
                        OP_BKSP: begin
                            if (cursor_q != '0) begin
                                we        = 1'b1;
                                waddr     = cursor_q - 1'b1;
                                dirty_set = 1'b1;
                                cursor_d  = cursor_q - 1'b1;
                            end
                        end
                        OP_CLEAR: begin
                            cursor_d  = '0;
                            clr_ptr_d = '0;
                            state_d   = ST_CLR;
                        end
                        default: ;
                    endcase
                end
            end
            default: state_d = ST_CLR;
        endcase
        // A new modification outranks a simultaneous acknowledge from the refresher
        dirty_d = dirty_set | (dirty_q & ~dirty_clr_i);
    end

    // Read-first lookup; out-of-range addresses read as a blank cell
    always_comb begin
        rd_data_d = FILL;
        if ({1'b0, rd_addr_i} < DEPTH_X) rd_data_d = mem_q[IDX_W'(rd_addr_i)];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clr_ptr_q   <= '0;
            cursor_q    <= '0;
            dirty_q     <= 1'b0;
            rd_data_q   <= '0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            clr_ptr_q   <= clr_ptr_d;
            cursor_q    <= cursor_d;
            dirty_q     <= dirty_d;
            rd_data_q   <= rd_data_d;
            cmd_ready_q <= (state_d == ST_IDLE);
            busy_q      <= (state_d == ST_CLR);
        end
    end

    // Cell storage has no reset; the sweep that follows reset initialises it
    always_ff @(posedge clk) begin
        if (we && !rst) mem_q[IDX_W'(waddr)] <= wdata;
    end

    assign cmd.cmd_ready = cmd_ready_q;
    assign rd_data_o     = rd_data_q;
    assign cursor_o      = cursor_q;
    assign busy_o        = busy_q;
    assign dirty_o       = dirty_q;
endmodule

// File: tb/tb_char_buffer_ctrl.sv
// Scoreboard bench for char_buffer_ctrl: directed scenarios plus random traffic against a cell-array model.
module tb_char_buffer_ctrl;
    localparam int DEPTH = 32;
    localparam int AW    = 6;
    localparam int DW    = 9;
    localparam logic [DW-1:0] FILL = 9'h120;

    logic clk = 1'b0;
    logic rst;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] cursor;
    logic busy, dirty, dirty_clr;

    char_buffer_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) cif ();

    char_buffer_ctrl #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW), .FILL(FILL)) dut (
        .clk(clk), .rst(rst), .cmd(cif.slave),
        .rd_addr_i(rd_addr), .rd_data_o(rd_data), .cursor_o(cursor),
        .busy_o(busy), .dirty_o(dirty), .dirty_clr_i(dirty_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] rd;
        bit            rd_chk;
        int            cur;
        bit            busy;
        bit            ready;
        bit            dirty;
    } exp_t;

    exp_t exp_q[$];
    exp_t me;
    int n_checks = 0;
    int n_err    = 0;

    // Reference model: plain cell array, cursor, and a count of how far the sweep has got
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_known [DEPTH];
    int            m_cur = 0;
    bit            m_dirty = 0;
    bit            sweeping = 0;
    int            sidx = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit v, input int op, input int a, input int d,
                        input int ra, input bit dc);
        exp_t e;
        bit   set;
        int   at, rat;
        @(negedge clk);
        at  = a & ((1 << AW) - 1);
        rat = ra & ((1 << AW) - 1);
        rst = r; cif.cmd_valid = v; cif.cmd_op = 2'(op);
        cif.cmd_addr = AW'(at); cif.cmd_data = DW'(d);
        rd_addr = AW'(rat); dirty_clr = dc;

        if (r)                 begin e.rd = '0;          e.rd_chk = 1'b1; end
        else if (rat >= DEPTH) begin e.rd = FILL;        e.rd_chk = 1'b1; end
        else                   begin e.rd = m_mem[rat];  e.rd_chk = m_known[rat]; end

        set = 1'b0;
        if (r) begin
            sweeping = 1'b1; sidx = 0; m_cur = 0; m_dirty = 1'b0;
        end else begin
            if (sweeping) begin
                m_mem[sidx] = FILL; m_known[sidx] = 1'b1;
                if (sidx == DEPTH - 1) begin sweeping = 1'b0; set = 1'b1; end
                else sidx++;
            end else if (v) begin
                case (op)
                    0: if (at < DEPTH) begin m_mem[at] = DW'(d); m_known[at] = 1'b1; set = 1'b1; end
                    1: begin
                        m_mem[m_cur] = DW'(d); m_known[m_cur] = 1'b1;
                        m_cur = (m_cur + 1) % DEPTH; set = 1'b1;
                    end
                    2: if (m_cur > 0) begin m_cur--; m_mem[m_cur] = FILL; m_known[m_cur] = 1'b1; set = 1'b1; end
                    default: begin m_cur = 0; sweeping = 1'b1; sidx = 0; end
                endcase
            end
            m_dirty = set || (m_dirty && !dc);
        end
        e.cur = m_cur; e.busy = sweeping; e.ready = !sweeping; e.dirty = m_dirty;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int ra);
        step(1'b0, 1'b0, 0, 0, 0, ra, 1'b0);
    endtask

    task automatic cmd(input int op, input int a, input int d);
        step(1'b0, 1'b1, op, a, d, $urandom_range(0, 39), 1'b0);
    endtask

    task automatic readback();
        for (int i = 0; i < 40; i++) idle(i);
    endtask

    task automatic sweep_wait();
        for (int i = 0; i < DEPTH + 2; i++) idle($urandom_range(0, 39));
    endtask

    // Monitor: rd_data and status are presented every cycle, one expectation per clock edge
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            me = exp_q.pop_front();
            if (me.rd_chk) chk("rd_data", 32'(rd_data), 32'(me.rd));
            chk("cursor",    32'(cursor),        32'(me.cur));
            chk("busy",      32'(busy),          32'(me.busy));
            chk("cmd_ready", 32'(cif.cmd_ready), 32'(me.ready));
            chk("dirty",     32'(dirty),         32'(me.dirty));
        end
    end

    initial begin
        rst = 1'b0; cif.cmd_valid = 1'b0; cif.cmd_op = '0; cif.cmd_addr = '0;
        cif.cmd_data = '0; rd_addr = '0; dirty_clr = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin m_mem[i] = '0; m_known[i] = 1'b0; end

        // Reset and initial sweep, then full readback
        step(1'b1, 1'b0, 0, 0, 0, 0, 1'b0);
        sweep_wait();
        readback();

        // Two appends and a read of cell 1
        cmd(1, 0, 'h148);
        cmd(1, 0, 'h161);
        idle(1); idle(0); idle(1);

        // Wrap the cursor with 32 appends, then one more
        cmd(3, 0, 0); sweep_wait();
        for (int i = 0; i < DEPTH; i++) cmd(1, 0, 'h100 | $urandom_range(0, 255));
        cmd(1, 0, 'h16F);
        readback();

        // Backspace at cursor 0 is a no-op; at cursor 2 it blanks cell 1
        cmd(3, 0, 0); sweep_wait();
        step(1'b0, 1'b0, 0, 0, 0, 0, 1'b1);
        cmd(2, 0, 0); idle(0); idle(0);
        cmd(1, 0, 'h141); cmd(1, 0, 'h142);
        step(1'b0, 1'b0, 0, 0, 0, 0, 1'b1);
        cmd(2, 0, 0);
        idle(0); idle(1); idle(2);

        // Write with read-first to the same address and simultaneous dirty_clr; out-of-range write
        step(1'b0, 1'b1, 0, 5, 'h16c, 5, 1'b1);
        idle(5); idle(5);
        step(1'b0, 1'b0, 0, 0, 0, 0, 1'b1);
        cmd(0, 40, 'h1AA);
        idle(8); readback();

        // Reset in the middle of a clear sweep restarts it; commands during the sweep are ignored
        cmd(3, 0, 0);
        for (int i = 0; i < 9; i++) cmd($urandom_range(0, 2), $urandom_range(0, 31), $urandom_range(0, 511));
        step(1'b1, 1'b1, 1, 0, 'h155, 0, 1'b0);
        for (int i = 0; i < DEPTH + 2; i++)
            cmd($urandom_range(0, 2), $urandom_range(0, 31), $urandom_range(0, 511));
        readback();

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            int op;
            op = ($urandom_range(0, 99) < 4) ? 3 : $urandom_range(0, 2);
            step($urandom_range(0, 299) == 0, $urandom_range(0, 9) < 7, op,
                 $urandom_range(0, 40), $urandom_range(0, 511),
                 $urandom_range(0, 40), $urandom_range(0, 4) == 0);
        end
        readback();

        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
        chk("drain", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
